// File: rtl/stack_pkg.sv
// Shared stack definitions: stack_op encodings and default geometry.
// Imported by stack_unit, the control unit and the processor top.
package stack_pkg;

   typedef enum logic [1:0] {
      STACK_NONE    = 2'b00,
      STACK_PUSH    = 2'b01,
      STACK_POP     = 2'b10,
      STACK_REPLACE = 2'b11
   } stack_op_e;

   localparam logic [1:0] PUSH_VALUE = STACK_PUSH;
   localparam logic [1:0] POP_VALUE  = STACK_POP;

   localparam int STACK_DEPTH     = 32;
   localparam int STACK_BASE_ADDR = 224;

endpackage

// File: rtl/stack_storage.sv
// Stack entry array: DEPTH x DATA_WIDTH registers, no reset.
// Ports: clock, we/waddr/wdata sync write, raddr -> rdata async read.
module stack_storage #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [IDX_WIDTH-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [IDX_WIDTH-1:0]  raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we && (32'(waddr) < DEPTH))
         mem[waddr] <= wdata;
   end

   // Non power-of-two depths leave unused index codes; read them as 0.
   always_comb begin
      rdata = '0;
      if (32'(raddr) < DEPTH)
         rdata = mem[raddr];
   end

endmodule

// File: rtl/stack_unit.sv
// Parametrised hardware stack: count, flags, sticky errors, pop return.
// Ports: clock, reset_n, stack_op, push_data, flush, err_clear -> outputs.
module stack_unit
   import stack_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = STACK_DEPTH,
   parameter int ADDR_WIDTH = 32,
   parameter int BASE_ADDR  = STACK_BASE_ADDR,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [1:0]            stack_op,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  flush,
   input  logic                  err_clear,
   output logic [DATA_WIDTH-1:0] top_data,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_valid,
   output logic [ADDR_WIDTH-1:0] sp,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow_err,
   output logic                  underflow_err
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  cnt_nxt;
   logic                  we;
   logic [IW-1:0]         waddr;
   logic [IW-1:0]         top_idx;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  take_pop;
   logic                  ovf_set;
   logic                  udf_set;

   assign full    = (cnt_q == CNT_WIDTH'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign top_idx = IW'(cnt_q - CNT_WIDTH'(1));

   stack_storage #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_WIDTH  (IW)
   ) u_storage (
      .clock (clock),
      .we    (we),
      .waddr (waddr),
      .wdata (push_data),
      .raddr (top_idx),
      .rdata (rdata)
   );

   always_comb begin
      cnt_nxt  = cnt_q;
      we       = 1'b0;
      waddr    = IW'(cnt_q);
      take_pop = 1'b0;
      ovf_set  = 1'b0;
      udf_set  = 1'b0;
      if (flush) begin
         cnt_nxt = '0;
      end else begin
         unique case (stack_op)
            STACK_PUSH: begin
               if (full) begin
                  ovf_set = 1'b1;
               end else begin
                  we      = 1'b1;
                  cnt_nxt = cnt_q + CNT_WIDTH'(1);
               end
            end
            STACK_POP: begin
               if (empty) begin
                  udf_set = 1'b1;
               end else begin
                  take_pop = 1'b1;
                  cnt_nxt  = cnt_q - CNT_WIDTH'(1);
               end
            end
            STACK_REPLACE: begin
               // Empty replace degenerates to a plain push (never full).
               if (empty) begin
                  we      = 1'b1;
                  cnt_nxt = cnt_q + CNT_WIDTH'(1);
               end else begin
                  take_pop = 1'b1;
                  we       = 1'b1;
                  waddr    = top_idx;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt_q         <= '0;
         pop_data      <= '0;
         pop_valid     <= 1'b0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         cnt_q     <= cnt_nxt;
         pop_valid <= take_pop;
         if (take_pop)
            pop_data <= rdata;
         // Later assignment lets a new error win over err_clear.
         if (err_clear) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
         end
         if (ovf_set)
            overflow_err <= 1'b1;
         if (udf_set)
            underflow_err <= 1'b1;
      end
   end

   assign count    = cnt_q;
   assign top_data = empty ? '0 : rdata;
   assign sp       = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(cnt_q);

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit (DEPTH=4, base 224).
// Drives one op per cycle and checks registered results 1ns after the edge.
module tb_stack_unit;
   import stack_pkg::*;

   logic        clock;
   logic        reset_n;
   logic [1:0]  stack_op;
   logic [31:0] push_data;
   logic        flush;
   logic        err_clear;
   logic [31:0] top_data;
   logic [31:0] pop_data;
   logic        pop_valid;
   logic [31:0] sp;
   logic [2:0]  count;
   logic        full;
   logic        empty;
   logic        overflow_err;
   logic        underflow_err;

   int n_chk;
   int n_err;

   stack_unit #(
      .DATA_WIDTH (32),
      .DEPTH      (4),
      .ADDR_WIDTH (32),
      .BASE_ADDR  (224)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .stack_op      (stack_op),
      .push_data     (push_data),
      .flush         (flush),
      .err_clear     (err_clear),
      .top_data      (top_data),
      .pop_data      (pop_data),
      .pop_valid     (pop_valid),
      .sp            (sp),
      .count         (count),
      .full          (full),
      .empty         (empty),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic [1:0] op, input logic [31:0] d,
                      input logic fl, input logic clr);
      stack_op  = op;
      push_data = d;
      flush     = fl;
      err_clear = clr;
      @(posedge clock);
      #1;
   endtask

   logic [31:0] fill [4];
   logic [31:0] drain [4];

   initial begin
      n_chk = 0;
      n_err = 0;
      fill  = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
      drain = '{32'hBB, 32'hA3, 32'hA2, 32'hA1};

      // Reset held two cycles with a push pending
      reset_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc(STACK_PUSH, 32'h77, 1'b0, 1'b0);
         chk("rst_pop_valid", 64'(pop_valid), 64'd0);
      end
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_sp", 64'(sp), 64'd224);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_top", 64'(top_data), 64'd0);
      chk("rst_pop_data", 64'(pop_data), 64'd0);
      chk("rst_ovf", 64'(overflow_err), 64'd0);
      chk("rst_udf", 64'(underflow_err), 64'd0);
      reset_n = 1'b1;

      // Fill
      for (int i = 0; i < 4; i++) begin
         cyc(STACK_PUSH, fill[i], 1'b0, 1'b0);
         chk("fill_count", 64'(count), 64'(i + 1));
         chk("fill_top", 64'(top_data), 64'(fill[i]));
      end
      chk("fill_full", 64'(full), 64'd1);
      chk("fill_sp", 64'(sp), 64'd228);

      // Overflow, replace while full, clear
      cyc(STACK_PUSH, 32'hFF, 1'b0, 1'b0);
      chk("ovf_count", 64'(count), 64'd4);
      chk("ovf_top", 64'(top_data), 64'hA4);
      chk("ovf_flag", 64'(overflow_err), 64'd1);
      chk("ovf_pop_valid", 64'(pop_valid), 64'd0);
      cyc(STACK_REPLACE, 32'hBB, 1'b0, 1'b0);
      chk("repl_pop_valid", 64'(pop_valid), 64'd1);
      chk("repl_pop_data", 64'(pop_data), 64'hA4);
      chk("repl_top", 64'(top_data), 64'hBB);
      chk("repl_count", 64'(count), 64'd4);
      chk("repl_ovf", 64'(overflow_err), 64'd1);
      cyc(STACK_NONE, 32'h0, 1'b0, 1'b1);
      chk("clr_ovf", 64'(overflow_err), 64'd0);
      chk("clr_pop_valid", 64'(pop_valid), 64'd0);
      chk("clr_pop_hold", 64'(pop_data), 64'hA4);

      // Drain back-to-back
      for (int i = 0; i < 4; i++) begin
         cyc(STACK_POP, 32'h0, 1'b0, 1'b0);
         chk("drain_valid", 64'(pop_valid), 64'd1);
         chk("drain_data", 64'(pop_data), 64'(drain[i]));
         chk("drain_count", 64'(count), 64'(3 - i));
      end
      chk("drain_empty", 64'(empty), 64'd1);
      chk("drain_sp", 64'(sp), 64'd224);
      chk("drain_top", 64'(top_data), 64'd0);
      cyc(STACK_NONE, 32'h0, 1'b0, 1'b0);
      chk("drain_pulse_end", 64'(pop_valid), 64'd0);
      chk("drain_pop_hold", 64'(pop_data), 64'hA1);

      // Underflow with simultaneous clear: set wins
      cyc(STACK_POP, 32'h0, 1'b0, 1'b1);
      chk("udf_flag", 64'(underflow_err), 64'd1);
      chk("udf_pop_valid", 64'(pop_valid), 64'd0);
      chk("udf_count", 64'(count), 64'd0);
      cyc(STACK_NONE, 32'h0, 1'b0, 1'b1);
      chk("udf_clr", 64'(underflow_err), 64'd0);

      // Replace on empty, then flush with push
      cyc(STACK_REPLACE, 32'h55, 1'b0, 1'b0);
      chk("repl_e_count", 64'(count), 64'd1);
      chk("repl_e_top", 64'(top_data), 64'h55);
      chk("repl_e_valid", 64'(pop_valid), 64'd0);
      chk("repl_e_udf", 64'(underflow_err), 64'd0);
      cyc(STACK_PUSH, 32'h66, 1'b1, 1'b0);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_top", 64'(top_data), 64'd0);
      chk("flush_ovf", 64'(overflow_err), 64'd0);
      chk("flush_empty", 64'(empty), 64'd1);

      // Interleaved ops
      cyc(STACK_PUSH, 32'h1, 1'b0, 1'b0);
      cyc(STACK_PUSH, 32'h2, 1'b0, 1'b0);
      cyc(STACK_POP, 32'h0, 1'b0, 1'b0);
      chk("mix_pop_valid", 64'(pop_valid), 64'd1);
      chk("mix_pop_data", 64'(pop_data), 64'h2);
      cyc(STACK_PUSH, 32'h3, 1'b0, 1'b0);
      chk("mix_top", 64'(top_data), 64'h3);
      chk("mix_count", 64'(count), 64'd2);
      chk("mix_sp", 64'(sp), 64'd226);
      chk("mix_valid_end", 64'(pop_valid), 64'd0);

      // Reset during a push
      reset_n = 1'b0;
      cyc(STACK_PUSH, 32'h9, 1'b0, 1'b0);
      reset_n = 1'b1;
      chk("mrst_count", 64'(count), 64'd0);
      chk("mrst_sp", 64'(sp), 64'd224);
      chk("mrst_top", 64'(top_data), 64'd0);
      chk("mrst_pop_data", 64'(pop_data), 64'd0);
      chk("mrst_empty", 64'(empty), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
